lime_ctrl_fsm: RTL and testbench
================================

LIME_CTRL_FSM -- requirements
Module: lime_ctrl_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles a memory access may wait for mem_ready; 0 disables the timeout.
REQ-002 Parameter TMO_W, default 5, width of the wait counter; SHALL satisfy 2^TMO_W > MEM_TIMEOUT.
REQ-003 Parameter ALUOP_W, default 4, ALUOp width; SHALL be >= 4.
REQ-004 CLK  in  1  clock, rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 run  in  1  enables a new fetch when high.
REQ-007 funct  in  4  instruction funct field, instr[6:3].
REQ-008 opcode  in  3  instruction opcode field, instr[2:0].
REQ-009 mem_ready  in  1  memory acknowledge for the current MemR/MemW.
REQ-010 Outputs: IoD, IRWrite, Mem2Reg, MemR, MemW, PCWrite, RegWrite, branch (all 1 bit); PCSrc, ALUSrcA, ALUSrcB, branchType (2 bits each); ALUOp (ALUOP_W bits).
REQ-011 retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
REQ-012 trap  out  1  sticky fault flag.
REQ-013 trap_cause  out  2  01 illegal opcode, 10 illegal funct, 11 memory timeout, 00 none.
REQ-014 state_o  out  4  current state encoding, for debug.

Function
REQ-015 States SHALL be: FETCH, DECODE, RTYPE, RITYPE, LUI, RTYPE_END, LW1, LW2, SW, JALR, BRANCH, BRANCH2, JAL, TRAP.
REQ-016 All outputs SHALL be Moore decodes of the state, except IRWrite, PCWrite and retire, which are additionally gated by mem_ready where stated below.
REQ-017 Default for every output in every state SHALL be 0, ALUOp = all-ones.
REQ-018 FETCH: MemR=1, ALUSrcB=1, ALUOp=0 (add). Asserted only when run=1. Stays in FETCH until mem_ready=1. IRWrite and PCWrite SHALL pulse only on the mem_ready cycle; the FSM then moves to DECODE.
REQ-019 DECODE transitions:
- opcode 000 -> RTYPE if funct <= 1000, else TRAP with cause 10.
- opcode 001: funct 1011 -> JALR; funct 11xx -> BRANCH; otherwise -> RITYPE.
- opcode 010 -> RITYPE.
- opcode 011 -> LUI.
- opcode 100 -> JAL.
- opcodes 101..111 -> TRAP with cause 01.
REQ-020 RTYPE: ALUOp=funct, ALUSrcA=2, ALUSrcB=0; next state RTYPE_END.
REQ-021 RITYPE: ALUOp=funct (add, i.e. 0, when funct is 1001 or 1010), ALUSrcA=2, ALUSrcB=2; next state LW1 for funct 1001, SW for funct 1010, otherwise RTYPE_END.
REQ-022 LUI: ALUOp=1010 (pass B), ALUSrcB=3; next state RTYPE_END.
REQ-023 RTYPE_END: RegWrite=1, retire=1; next state FETCH.
REQ-024 LW1: IoD=1, MemR=1; wait for mem_ready, then LW2. LW2: Mem2Reg=1, RegWrite=1, retire=1; next state FETCH.
REQ-025 SW: IoD=1, MemW=1; wait for mem_ready; retire SHALL pulse on the mem_ready cycle; next state FETCH.
REQ-026 JALR: ALUOp=0111, ALUSrcA=3, ALUSrcB=1, RegWrite=1, PCWrite=1, PCSrc=1, retire=1; next state FETCH.
REQ-027 BRANCH: ALUOp=1001, ALUSrcB=2, branch=1, branchType=funct[1:0]; next state BRANCH2.
REQ-028 BRANCH2: ALUOp=0001, ALUSrcA=2, branch=1, branchType=funct[1:0], PCSrc=1, PCWrite=1, retire=1; next state FETCH.
REQ-029 JAL: ALUOp=0111, ALUSrcA=3, ALUSrcB=1, RegWrite=1, PCWrite=1, PCSrc=2, retire=1; next state FETCH.
REQ-030 Wait counter: cleared on entry to FETCH, LW1 and SW; increments each cycle mem_ready=0 in those states. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the FSM SHALL go to TRAP with cause 11.
REQ-031 If mem_ready=1 on the same cycle the timeout would fire, mem_ready SHALL win and no trap occurs.
REQ-032 TRAP: all strobes 0, trap=1; held until Reset. trap_cause SHALL be latched on entry.
REQ-033 run=0 SHALL have no effect on an instruction already past FETCH.
REQ-034 If an unknown state encoding is reached, the next state SHALL be FETCH.

Reset
REQ-035 On Reset: state=FETCH, wait counter=0, trap=0, trap_cause=00; all outputs take their FETCH-with-run=0 values (all zero).
REQ-036 Reset asserted mid-instruction SHALL abort it immediately, with no RegWrite or MemW pulse.

Structure
REQ-037 State encodings, opcode/funct constants and trap cause codes SHALL live in shared package lime_pkg.
REQ-038 The wait/timeout counter SHALL be sub-module lime_wait_timer (inputs clear, count, ready; output expired); the rest is a single FSM.

Verification
REQ-039 add (op 000, funct 0000), mem_ready=1 -> FETCH, DECODE, RTYPE, RTYPE_END; RegWrite and retire high in cycle 4.
REQ-040 lw (op 010, funct 1001) with mem_ready low for 3 cycles in LW1 -> LW1 held 4 cycles, then LW2 with Mem2Reg=1, RegWrite=1.
REQ-041 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, trap_cause=11, held until Reset.
REQ-042 op 101 -> TRAP with cause 01; op 000 with funct 1100 -> TRAP with cause 10; no RegWrite in either case.
REQ-043 beq-class instruction (op 001, funct 1110) -> BRANCH then BRANCH2 with branchType=10, PCWrite=1.
REQ-044 Reset asserted during SW wait -> state_o=FETCH next edge, MemW=0, trap=0.

Source files
------------

// File: rtl/lime_pkg.sv
// lime_pkg -- constants and types that the lime control FSM and its
// wait timer share.
//   state_e   : FSM state encoding, which also appears on state_o
//   cause_e   : trap cause codes that appear on trap_cause
//   OP_*/FN_* : opcode and funct values that the decoder recognises
//   ALU_*     : fixed ALUOp values for states that do not pass funct
//   decode_instr() : maps the opcode/funct pair to the state that
//                    follows DECODE, plus the trap cause if it is a trap
package lime_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_RTYPE     = 4'd2,
    S_RITYPE    = 4'd3,
    S_LUI       = 4'd4,
    S_RTYPE_END = 4'd5,
    S_LW1       = 4'd6,
    S_LW2       = 4'd7,
    S_SW        = 4'd8,
    S_JALR      = 4'd9,
    S_BRANCH    = 4'd10,
    S_BRANCH2   = 4'd11,
    S_JAL       = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_OPCODE  = 2'b01,
    CAUSE_FUNCT   = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_RIMM  = 3'b001;
  localparam logic [2:0] OP_MEM   = 3'b010;
  localparam logic [2:0] OP_LUI   = 3'b011;
  localparam logic [2:0] OP_JAL   = 3'b100;

  localparam logic [3:0] FN_RTYPE_MAX = 4'b1000;
  localparam logic [3:0] FN_LW        = 4'b1001;
  localparam logic [3:0] FN_SW        = 4'b1010;
  localparam logic [3:0] FN_JALR      = 4'b1011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_LINK  = 4'b0111;
  localparam logic [3:0] ALU_CMP   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    state_e nxt;
    cause_e cause;
  } decode_t;

  function automatic decode_t decode_instr(input logic [2:0] opcode,
                                           input logic [3:0] funct);
    decode_t d;
    d.nxt   = S_TRAP;
    d.cause = CAUSE_OPCODE;
    case (opcode)
      OP_RTYPE: begin
        if (funct <= FN_RTYPE_MAX) begin
          d.nxt   = S_RTYPE;
          d.cause = CAUSE_NONE;
        end else begin
          d.cause = CAUSE_FUNCT;
        end
      end
      OP_RIMM: begin
        d.cause = CAUSE_NONE;
        if (funct == FN_JALR)          d.nxt = S_JALR;
        else if (funct[3:2] == 2'b11)  d.nxt = S_BRANCH;
        else                           d.nxt = S_RITYPE;
      end
      OP_MEM: begin
        d.nxt   = S_RITYPE;
        d.cause = CAUSE_NONE;
      end
      OP_LUI: begin
        d.nxt   = S_LUI;
        d.cause = CAUSE_NONE;
      end
      OP_JAL: begin
        d.nxt   = S_JAL;
        d.cause = CAUSE_NONE;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lime_wait_timer.sv
// lime_wait_timer -- counts the cycles a memory access has been waiting
// for mem_ready, and flags when the access has run out of time.
//   CLK, Reset : clock, asynchronous active-high reset
//   clear      : zero the counter (takes priority over counting)
//   count      : a memory access is in progress this cycle
//   ready      : memory acknowledge
//   expired    : this cycle is the MEM_TIMEOUT-th consecutive cycle
//                without ready; combinational, never set when ready=1
module lime_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // The counter saturates so that it cannot wrap into a false expiry
  // when the timeout is disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The access expires on the cycle in which the counter would reach
  // MEM_TIMEOUT. The access then occupies exactly MEM_TIMEOUT cycles.
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = count && !ready && (cnt_q == TMO_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/lime_ctrl_fsm.sv
// lime_ctrl_fsm -- multicycle control FSM for the lime core.
//   CLK, Reset            : clock, asynchronous active-high reset
//   run                   : allows a new instruction fetch
//   funct, opcode         : fields of the instruction register
//   mem_ready             : acknowledge for the current MemR/MemW
//   IoD..branchType,ALUOp : datapath controls, decoded from the state
//                           (IRWrite, PCWrite and retire are also gated
//                           by mem_ready where the state waits on memory)
//   retire                : last cycle of a completed instruction
//   trap, trap_cause      : sticky fault flag and its latched cause
//   state_o               : current state, for debug
module lime_ctrl_fsm
  import lime_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5,
  parameter int ALUOP_W     = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               run,
  input  logic [3:0]         funct,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  output logic               IoD,
  output logic               IRWrite,
  output logic               Mem2Reg,
  output logic               MemR,
  output logic               MemW,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               branch,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         branchType,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               retire,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);

  state_e  state_q, state_d;
  cause_e  cause_q, cause_d;
  decode_t dec;
  logic    tmr_clear, tmr_count, tmr_expired;

  assign dec = decode_instr(opcode, funct);

  // Only a fetch with run=1, a load or a store is waiting on memory.
  assign tmr_count = ((state_q == S_FETCH) && run) || (state_q == S_LW1) ||
                     (state_q == S_SW);
  // Clearing on every state change gives a zero count on entry to each
  // waiting state. An idle FETCH also clears, so that a fetch measures its
  // wait from the cycle in which run rises.
  assign tmr_clear = (state_d != state_q) || ((state_q == S_FETCH) && !run);

  lime_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_wait_timer (
    .CLK    (CLK),
    .Reset  (Reset),
    .clear  (tmr_clear),
    .count  (tmr_count),
    .ready  (mem_ready),
    .expired(tmr_expired)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    IoD        = 1'b0;
    IRWrite    = 1'b0;
    Mem2Reg    = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    branch     = 1'b0;
    PCSrc      = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    branchType = 2'd0;
    ALUOp      = '1;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // ALUOp stays at add even while idle, so an idle FETCH (and
        // therefore reset) drives every output to zero.
        ALUOp = ALUOP_W'(ALU_ADD);
        if (run) begin
          MemR    = 1'b1;
          ALUSrcB = 2'd1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end else if (tmr_expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        state_d = dec.nxt;
        if (dec.nxt == S_TRAP) cause_d = dec.cause;
      end
      S_RTYPE: begin
        ALUOp   = ALUOP_W'(funct);
        ALUSrcA = 2'd2;
        state_d = S_RTYPE_END;
      end
      S_RITYPE: begin
        // Load and store funct codes reuse the ALU for an address add.
        ALUOp   = ((funct == FN_LW) || (funct == FN_SW)) ? ALUOP_W'(ALU_ADD)
                                                         : ALUOP_W'(funct);
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
        if (funct == FN_LW)      state_d = S_LW1;
        else if (funct == FN_SW) state_d = S_SW;
        else                     state_d = S_RTYPE_END;
      end
      S_LUI: begin
        ALUOp   = ALUOP_W'(ALU_PASSB);
        ALUSrcB = 2'd3;
        state_d = S_RTYPE_END;
      end
      S_RTYPE_END: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_LW1: begin
        IoD  = 1'b1;
        MemR = 1'b1;
        if (mem_ready) begin
          state_d = S_LW2;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_LW2: begin
        Mem2Reg  = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_SW: begin
        IoD  = 1'b1;
        MemW = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_JALR: begin
        ALUOp    = ALUOP_W'(ALU_LINK);
        ALUSrcA  = 2'd3;
        ALUSrcB  = 2'd1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSrc    = 2'd1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp      = ALUOP_W'(ALU_CMP);
        ALUSrcB    = 2'd2;
        branch     = 1'b1;
        branchType = funct[1:0];
        state_d    = S_BRANCH2;
      end
      S_BRANCH2: begin
        ALUOp      = ALUOP_W'(ALU_SUB);
        ALUSrcA    = 2'd2;
        branch     = 1'b1;
        branchType = funct[1:0];
        PCSrc      = 2'd1;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUOp    = ALUOP_W'(ALU_LINK);
        ALUSrcA  = 2'd3;
        ALUSrcB  = 2'd1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSrc    = 2'd2;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: ;  // held with every strobe low until Reset
      default: state_d = S_FETCH;
    endcase
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_lime_ctrl_fsm.sv
module tb_lime_ctrl_fsm;
  import lime_pkg::*;

  localparam int T = 4;  // MEM_TIMEOUT of the unit under test

  logic       CLK = 1'b0;
  logic       Reset, run, mem_ready;
  logic [3:0] funct;
  logic [2:0] opcode;
  logic       IoD, IRWrite, Mem2Reg, MemR, MemW, PCWrite, RegWrite, branch;
  logic [1:0] PCSrc, ALUSrcA, ALUSrcB, branchType, trap_cause;
  logic [3:0] ALUOp, state_o;
  logic       retire, trap;

  lime_ctrl_fsm #(.MEM_TIMEOUT(T), .TMO_W(5), .ALUOP_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .run(run), .funct(funct), .opcode(opcode),
    .mem_ready(mem_ready), .IoD(IoD), .IRWrite(IRWrite), .Mem2Reg(Mem2Reg),
    .MemR(MemR), .MemW(MemW), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .branch(branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .branchType(branchType), .ALUOp(ALUOp), .retire(retire), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       iod, irw, m2r, memr, memw, pcw, regw, br;
    logic [1:0] pcsrc, srca, srcb, bt;
    logic [3:0] aluop;
    logic       retire, trap;
    logic [1:0] cause;
  } ctrl_t;

  typedef struct {
    bit         run, mr;
    logic [2:0] op;
    logic [3:0] fn;
    logic [3:0] st;
    ctrl_t      c;
  } ent_t;

  ctrl_t obs;
  assign obs = {IoD, IRWrite, Mem2Reg, MemR, MemW, PCWrite, RegWrite, branch,
                PCSrc, ALUSrcA, ALUSrcB, branchType, ALUOp, retire, trap,
                trap_cause};

  ent_t       q[$];
  logic [2:0] cur_op;
  logic [3:0] cur_fn;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: observed %h expected %h (op=%0d fn=%0d)",
               tag, $time, got, exp, cur_op, cur_fn);
    end
  endtask

  function automatic ctrl_t dflt();
    ctrl_t c = '0;
    c.aluop = 4'hF;
    return c;
  endfunction

  task automatic push(input bit r, input bit m, input logic [3:0] st,
                      input ctrl_t c);
    ent_t e;
    e.run = r; e.mr = m; e.op = cur_op; e.fn = cur_fn; e.st = st; e.c = c;
    q.push_back(e);
  endtask

  // Cycles that do not wait on memory: run and mem_ready must not matter.
  task automatic push_any(input logic [3:0] st, input ctrl_t c);
    push(1'($urandom), 1'($urandom), st, c);
  endtask

  task automatic push_trap(input logic [1:0] cause);
    ctrl_t c = dflt();
    c.trap = 1'b1; c.cause = cause;
    for (int i = 0; i < 3; i++) push_any(S_TRAP, c);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom), S_FETCH, '0);
  endtask

  // A memory access in state st with w cycles of mem_ready low.
  task automatic mem_phase(input logic [3:0] st, input ctrl_t cw,
                           input ctrl_t cr, input int w, output bit trapped);
    for (int i = 0; i < w && i < T; i++) push(1'($urandom), 1'b0, st, cw);
    trapped = (w >= T);
    if (trapped) push_trap(2'b11);
    else         push(1'($urandom), 1'b1, st, cr);
  endtask

  task automatic end_phase();
    ctrl_t c = dflt();
    c.regw = 1'b1; c.retire = 1'b1;
    push_any(S_RTYPE_END, c);
  endtask

  // Expected cycle-by-cycle trace of one instruction: fw and mw are the
  // numbers of mem_ready-low cycles in the fetch and in the data access.
  task automatic build(input logic [2:0] op, input logic [3:0] fn,
                       input int fw, input int mw, output bit trapped);
    ctrl_t c, cr;
    cur_op = op; cur_fn = fn; trapped = 1'b0;
    c = dflt(); c.aluop = 4'd0; c.memr = 1'b1; c.srcb = 2'd1;
    cr = c; cr.irw = 1'b1; cr.pcw = 1'b1;
    for (int i = 0; i < fw && i < T; i++) push(1'b1, 1'b0, S_FETCH, c);
    if (fw >= T) begin push_trap(2'b11); trapped = 1'b1; return; end
    push(1'b1, 1'b1, S_FETCH, cr);
    push_any(S_DECODE, dflt());
    if (op == 3'd0) begin
      if (fn > 4'd8) begin push_trap(2'b10); trapped = 1'b1; return; end
      c = dflt(); c.aluop = fn; c.srca = 2'd2; c.srcb = 2'd0;
      push_any(S_RTYPE, c); end_phase();
    end else if (op == 3'd1 && fn == 4'd11) begin
      c = dflt(); c.aluop = 4'd7; c.srca = 2'd3; c.srcb = 2'd1; c.regw = 1'b1;
      c.pcw = 1'b1; c.pcsrc = 2'd1; c.retire = 1'b1;
      push_any(S_JALR, c);
    end else if (op == 3'd1 && fn >= 4'd12) begin
      c = dflt(); c.aluop = 4'd9; c.srcb = 2'd2; c.br = 1'b1; c.bt = fn[1:0];
      push_any(S_BRANCH, c);
      c = dflt(); c.aluop = 4'd1; c.srca = 2'd2; c.br = 1'b1; c.bt = fn[1:0];
      c.pcsrc = 2'd1; c.pcw = 1'b1; c.retire = 1'b1;
      push_any(S_BRANCH2, c);
    end else if (op == 3'd1 || op == 3'd2) begin
      c = dflt(); c.aluop = (fn == 4'd9 || fn == 4'd10) ? 4'd0 : fn;
      c.srca = 2'd2; c.srcb = 2'd2;
      push_any(S_RITYPE, c);
      if (fn == 4'd9) begin
        c = dflt(); c.iod = 1'b1; c.memr = 1'b1;
        mem_phase(S_LW1, c, c, mw, trapped);
        if (!trapped) begin
          c = dflt(); c.m2r = 1'b1; c.regw = 1'b1; c.retire = 1'b1;
          push_any(S_LW2, c);
        end
      end else if (fn == 4'd10) begin
        c = dflt(); c.iod = 1'b1; c.memw = 1'b1;
        cr = c; cr.retire = 1'b1;
        mem_phase(S_SW, c, cr, mw, trapped);
      end else begin
        end_phase();
      end
    end else if (op == 3'd3) begin
      c = dflt(); c.aluop = 4'd10; c.srcb = 2'd3;
      push_any(S_LUI, c); end_phase();
    end else if (op == 3'd4) begin
      c = dflt(); c.aluop = 4'd7; c.srca = 2'd3; c.srcb = 2'd1; c.regw = 1'b1;
      c.pcw = 1'b1; c.pcsrc = 2'd2; c.retire = 1'b1;
      push_any(S_JAL, c);
    end else begin
      push_trap(2'b01); trapped = 1'b1;
    end
  endtask

  // Drive each queued cycle and compare; stop_sw ends after the first
  // SW cycle and drops the rest of the trace.
  task automatic play(input bit stop_sw);
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge CLK);
      run = e.run; mem_ready = e.mr; opcode = e.op; funct = e.fn;
      #2;
      check_eq("state", 32'(state_o), 32'(e.st));
      check_eq("ctrl", 32'(obs), 32'(e.c));
      if (stop_sw && e.st == 4'(S_SW)) q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1; run = 1'b0;
    #1;
    check_eq("rst_state", 32'(state_o), 32'(S_FETCH));
    check_eq("rst_ctrl", 32'(obs), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [3:0] fn,
                           input int fw, input int mw);
    bit trapped;
    push_idle($urandom_range(0, 2));
    build(op, fn, fw, mw, trapped);
    play(1'b0);
    if (trapped) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    cur_op = '0; cur_fn = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_state", 32'(state_o), 32'(S_FETCH));
    check_eq("reset_ctrl", 32'(obs), 32'd0);
    Reset = 1'b0;

    run_instr(3'd0, 4'd0, 0, 0);    // add
    run_instr(3'd2, 4'd9, 0, 3);    // lw, 3 wait cycles in LW1
    run_instr(3'd0, 4'd0, 10, 0);   // fetch timeout
    run_instr(3'd5, 4'd0, 0, 0);    // illegal opcode
    run_instr(3'd0, 4'd12, 0, 0);   // illegal funct
    run_instr(3'd1, 4'd14, 0, 0);   // beq-class branch
    run_instr(3'd2, 4'd10, 1, 2);   // sw
    run_instr(3'd0, 4'd5, T-1, 0);  // ready on the last allowed fetch cycle
    run_instr(3'd2, 4'd9, 0, T);    // load timeout
    run_instr(3'd2, 4'd10, 0, T-1); // store ready on the last allowed cycle
    run_instr(3'd3, 4'd6, 0, 0);    // lui
    run_instr(3'd4, 4'd2, 0, 0);    // jal
    run_instr(3'd1, 4'd11, 2, 0);   // jalr
    run_instr(3'd1, 4'd3, 0, 0);    // immediate ALU op
    run_instr(3'd0, 4'd8, 0, 0);    // highest legal R-type funct

    // Reset during a store wait aborts it without a write.
    begin
      bit trapped;
      build(3'd2, 4'd10, 0, 3, trapped);
      play(1'b1);
      @(negedge CLK);
      Reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
      @(posedge CLK); #1;
      check_eq("swrst_state", 32'(state_o), 32'(S_FETCH));
      check_eq("swrst_memw", 32'(MemW), 32'd0);
      check_eq("swrst_regw", 32'(RegWrite), 32'd0);
      check_eq("swrst_trap", 32'(trap), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
    end

    for (int k = 0; k < 250; k++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2)
                                        : $urandom_range(0, T - 1);
      mw = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2)
                                        : $urandom_range(0, T - 1);
      run_instr(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), fw, mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
